dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single `dram_control` user port (valid/ready/addr/wmask/wdata/rdata) between NREQ requesters, e.g. CPU fetch, CPU load/store, video scan-out and a test-pattern generator.
- Picks one request round-robin, registers it and drives it to `dram_control` until ready.
- Returns read data to the granted requester with a one-cycle ready pulse.
- Sits between the requesters and `dram_control`, in the `clk` domain.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 128, data width (one DRAM burst)

Ports:
- clk  in  1  system clock, also the `dram_control` clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester request; held until the matching req_ready
- req_ready  out  NREQ  one-cycle completion pulse, at most one bit set
- req_addr  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW]
- req_wmask  in  NREQ  1 = write, 0 = read
- req_wdata  in  NREQ*DW  packed write data
- req_rdata  out  DW  read data, broadcast to all requesters; valid when req_ready[i]=1
- mem_valid  out  1  to `dram_control` valid
- mem_ready  in  1  from `dram_control` ready
- mem_addr  out  AW  to `dram_control` addr
- mem_wmask  out  1  to `dram_control` wmask
- mem_wdata  out  DW  to `dram_control` wdata
- mem_rdata  in  DW  from `dram_control` rdata
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE, mem_valid=0, req_ready=0, req_rdata=0, mem_addr/mem_wdata/mem_wmask=0, grant_id=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Reset mid-transaction abandons it; no req_ready is issued.
  - `dram_control` must be reset alongside, by the same rstn.
- States IDLE, BUSY, RESP. The FSM is a registered state with registered outputs.
- IDLE:
  - If any req_valid is set, choose the first set bit scanning from last+1 upward with wrap modulo NREQ.
  - Latch the chosen requester's addr, wmask and wdata into mem_*; grant_id<=g; last<=g; mem_valid<=1; go to BUSY.
  - If no req_valid is set, stay in IDLE.
- BUSY:
  - mem_valid held at 1 and mem_* held stable.
  - On mem_ready=1: mem_valid<=0; req_rdata<=mem_rdata (captured even for writes); req_ready[g]<=1; go to RESP.
- RESP:
  - req_ready[g] is high for exactly this cycle; the requester samples rdata and may drop or change req_valid at the next edge.
  - req_ready<=0; go to IDLE.
- Latency:
  - request at IDLE cycle t -> mem_valid at t+1.
  - mem_ready at cycle k -> req_ready at k+1.
  - Next arbitration decision at k+2.
  - Minimum occupancy: 3 cycles plus DRAM latency.
- Boundary conditions:
  - mem_ready in IDLE or RESP is ignored.
  - mem_ready in the same cycle as mem_valid rises is accepted.
  - A requester dropping req_valid while in BUSY is a protocol violation; the transaction still completes and req_ready still pulses.
  - Requester inputs are not sampled outside IDLE.
  - All requesters valid continuously -> strict rotation 0,1,2,3,0… with no repeats.
  - Only one requester valid -> it is granted back-to-back every RESP+IDLE turn.

Optional Feature:
- Macro: DRAM_ARB_PRIO0_EN.
- When defined, requester 0 (video scan-out) wins IDLE arbitration whenever req_valid[0]=1, regardless of the round-robin pointer. Requesters 1..NREQ-1 rotate round-robin among themselves, with last updated only on their grants.
- When undefined, plain round-robin across all NREQ requesters as above.

Decomposition:
- Package `dram_pkg` holds:
  - the AW/DW default constants, shared with `dram_control`;
  - the arbiter state enum {IDLE, BUSY, RESP};
  - the requester index type sized for the maximum NREQ.
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs: request vector and last pointer. Outputs: grant index and any-valid.
- `rr_pick` is reusable by future bus arbiters.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with req_valid=4'b1111 -> mem_valid=0, req_ready=0, grant_id=0. After release, the first grant goes to requester 0.
- Single write: req_valid[2]=1, addr=0x100, wmask=1, wdata=128'hdeadbeef, mem_ready pulsed 5 cycles after mem_valid rises.
  - mem_addr=0x100, mem_wmask=1 and mem_wdata=128'hdeadbeef, all stable.
  - req_ready=4'b0100 for exactly one cycle, one cycle after mem_ready.
- Read data return: requester 1 reads with mem_rdata=128'h0123456789abcdef -> req_rdata equals that value while req_ready[1]=1.
- Fairness: all four requesters valid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- Reset mid-operation: rstn=0 while in BUSY -> mem_valid=0 next cycle and no req_ready pulse. A new request after reset is granted to requester 0.
- With DRAM_ARB_PRIO0_EN defined: req 0 and req 3 continuously valid -> grants 0,0,0… and requester 3 is never granted. After req_valid[0] drops, requester 3 is granted next.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared DRAM definitions: default address/data widths, arbiter states and
// the requester index type sized for the largest supported arbiter.
package dram_pkg;

    localparam int DRAM_AW   = 32;
    localparam int DRAM_DW   = 128;
    localparam int MAX_NREQ  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef logic [$clog2(MAX_NREQ)-1:0] req_idx_t;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit scanning upward
// from last+1, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any
);

    int idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one dram_control port between NREQ requesters.
// Define DRAM_ARB_PRIO0_EN to give requester 0 absolute priority in IDLE.
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = DRAM_AW,
    parameter int DW   = DRAM_DW,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]   req_wmask,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [DW-1:0]     req_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_wmask,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic [IW-1:0]     grant_id
);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic               mem_valid_q, mem_valid_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic               mem_wmask_q, mem_wmask_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic [NREQ-1:0]    req_ready_q, req_ready_d;
    logic [DW-1:0]      rdata_q, rdata_d;

    logic [AW-1:0]      addrArr  [NREQ];
    logic [DW-1:0]      wdataArr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addrArr[i]  = req_addr[i*AW +: AW];
        assign wdataArr[i] = req_wdata[i*DW +: DW];
    end

    logic [NREQ-1:0]    rrReq;
    logic [IW-1:0]      rrIdx;
    logic               rrAny;
    logic [IW-1:0]      pickIdx;
    logic               pickAny;
    logic               pickFromRr;

`ifdef DRAM_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation; the pointer only tracks 1..NREQ-1.
    assign rrReq      = req_valid & ~NREQ'(1);
    assign pickFromRr = !req_valid[0];
    assign pickIdx    = req_valid[0] ? '0 : rrIdx;
    assign pickAny    = req_valid[0] | rrAny;
`else
    assign rrReq      = req_valid;
    assign pickFromRr = 1'b1;
    assign pickIdx    = rrIdx;
    assign pickAny    = rrAny;
`endif

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (rrReq),
        .last  (last_q),
        .grant (rrIdx),
        .any   (rrAny)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            grant_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wmask_q <= 1'b0;
            mem_wdata_q <= '0;
            req_ready_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
            req_ready_q <= req_ready_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wmask_d = mem_wmask_q;
        mem_wdata_d = mem_wdata_q;
        req_ready_d = req_ready_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pickAny) begin
                    mem_addr_d  = addrArr[pickIdx];
                    mem_wmask_d = req_wmask[pickIdx];
                    mem_wdata_d = wdataArr[pickIdx];
                    grant_d     = pickIdx;
                    mem_valid_d = 1'b1;
                    state_d     = BUSY;
                    if (pickFromRr) begin
                        last_d = pickIdx;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    rdata_d     = mem_rdata;
                    req_ready_d = NREQ'(1) << grant_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                req_ready_d = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign req_rdata = rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: a table of transactions plus
// hand-written reset, idle and mid-transaction reset sequences.
module tb_dram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 128;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   req_wmask;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     req_rdata;
    logic              mem_valid;
    logic              mem_ready;
    logic [AW-1:0]     mem_addr;
    logic              mem_wmask;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic [1:0]        grant_id;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] addrOf  [NREQ];
    logic [DW-1:0] wdataOf [NREQ];

    typedef struct {
        logic [NREQ-1:0] mask;
        int              lat;
        logic [DW-1:0]   rd;
        int              expRr;
        int              expP0;
    } vec_t;

    vec_t vecs [14];

    dram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic stepClk();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction from an IDLE cycle; leaves the DUT back in IDLE.
    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int lat,
                                 input logic [DW-1:0] rd, input int expG);
        logic [AW-1:0] a0;
        req_valid = mask;
        stepClk();
        checkOutput("grant_id", DW'(grant_id), DW'(expG));
        checkOutput("mem_valid rise", DW'(mem_valid), DW'(1));
        checkOutput("mem_addr", DW'(mem_addr), DW'(addrOf[expG]));
        checkOutput("mem_wmask", DW'(mem_wmask), DW'(expG == 2));
        checkOutput("mem_wdata", mem_wdata, wdataOf[expG]);
        a0 = mem_addr;
        for (int c = 0; c < lat; c++) begin
            stepClk();
            checkOutput("busy stable", DW'({mem_valid, mem_addr}), DW'({1'b1, a0}));
            checkOutput("no early ready", DW'(req_ready), DW'(0));
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        stepClk();
        mem_ready = 1'b0;
        checkOutput("req_ready pulse", DW'(req_ready), DW'(4'b0001 << expG));
        checkOutput("req_rdata", req_rdata, rd);
        checkOutput("mem_valid drop", DW'(mem_valid), DW'(0));
        stepClk();
        checkOutput("req_ready end", DW'(req_ready), DW'(0));
    endtask

    initial begin
        addrOf[0] = 32'h0000_1000;  wdataOf[0] = 128'ha000;
        addrOf[1] = 32'h0000_1040;  wdataOf[1] = 128'ha001;
        addrOf[2] = 32'h0000_0100;  wdataOf[2] = 128'hdeadbeef;
        addrOf[3] = 32'h0000_10c0;  wdataOf[3] = 128'ha003;
        req_addr  = {addrOf[3], addrOf[2], addrOf[1], addrOf[0]};
        req_wdata = {wdataOf[3], wdataOf[2], wdataOf[1], wdataOf[0]};
        req_wmask = 4'b0100;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{4'b1111, i % 3, DW'(128'h5500 + i), i % 4, 0};
        end
        vecs[8]  = '{4'b0100, 5, 128'h0,                 2, 2};
        vecs[9]  = '{4'b0100, 0, 128'h77,                2, 2};
        vecs[10] = '{4'b0010, 2, 128'h0123456789abcdef,  1, 1};
        vecs[11] = '{4'b1001, 1, 128'h11,                3, 0};
        vecs[12] = '{4'b1001, 1, 128'h22,                0, 0};
        vecs[13] = '{4'b1000, 1, 128'h33,                3, 3};

        rstn      = 1'b0;
        req_valid = 4'b1111;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (3) stepClk();
        checkOutput("reset mem_valid", DW'(mem_valid), DW'(0));
        checkOutput("reset req_ready", DW'(req_ready), DW'(0));
        checkOutput("reset grant_id", DW'(grant_id), DW'(0));
        checkOutput("reset mem_addr", DW'(mem_addr), DW'(0));
        checkOutput("reset req_rdata", req_rdata, '0);
        rstn = 1'b1;

        for (int i = 0; i < 14; i++) begin
`ifdef DRAM_ARB_PRIO0_EN
            applyStimulus(vecs[i].mask, vecs[i].lat, vecs[i].rd, vecs[i].expP0);
`else
            applyStimulus(vecs[i].mask, vecs[i].lat, vecs[i].rd, vecs[i].expRr);
`endif
        end

        // mem_ready while IDLE must not start or complete anything
        req_valid = '0;
        mem_ready = 1'b1;
        repeat (2) stepClk();
        checkOutput("idle mem_valid", DW'(mem_valid), DW'(0));
        checkOutput("idle req_ready", DW'(req_ready), DW'(0));
        mem_ready = 1'b0;

        // reset abandons a transaction in BUSY
        req_valid = 4'b0010;
        stepClk();
        checkOutput("midrst granted", DW'({mem_valid, grant_id}), DW'({1'b1, 2'd1}));
        stepClk();
        rstn      = 1'b0;
        mem_ready = 1'b1;
        stepClk();
        checkOutput("midrst mem_valid", DW'(mem_valid), DW'(0));
        checkOutput("midrst req_ready", DW'(req_ready), DW'(0));
        checkOutput("midrst grant_id", DW'(grant_id), DW'(0));
        rstn      = 1'b1;
        mem_ready = 1'b0;
        req_valid = '0;
        stepClk();
        checkOutput("midrst no pulse", DW'(req_ready), DW'(0));
        applyStimulus(4'b1111, 1, 128'h99, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
